gray_counter_param: RTL and testbench

// - Parametrised up/down counter that keeps a binary count and its registered

---
 rtl/gray_counter_param.sv | 128 ++++++++++++
 tb/tb_gray_counter_param.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/gray_counter_param.sv
`default_nettype none
// ============================================================================
//  Module      : gray_counter_param
//  Description : Parametrised up/down counter. It keeps a binary count and a
//                registered Gray-code copy of that count, and both update on
//                the same clock edge. Other features: parallel load of a
//                Gray-coded value, wrap or saturate at the ends of the range,
//                a one-cycle wrap pulse, and a terminal-count level flag.
//                The Gray output drives single-bit-change pointers used by
//                clock-domain-crossing and encoder logic.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    WIDTH     counter/code width in bits (>= 2)
//    WRAP_EN   1 = modulo 2^WIDTH wrap-around, 0 = saturate at max/min
//  Ports
//    clk        in   1      rising-edge clock
//    rst        in   1      asynchronous assert, active-high reset
//    en         in   1      count enable, one step per cycle while high
//    up_dn      in   1      1 = count up, 0 = count down
//    load       in   1      load load_gray this cycle (overrides en)
//    load_gray  in   WIDTH  Gray-coded load value
//    bin_out    out  WIDTH  registered binary count
//    gray_out   out  WIDTH  registered Gray code of bin_out
//    wrap       out  1      registered pulse on max->0 or 0->max
//    at_limit   out  1      bin_out at the end of the range in the current
//                           direction (combinational)
// ============================================================================
module gray_counter_param #(
  parameter int WIDTH   = 4,
  parameter bit WRAP_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_gray,
  output logic [WIDTH-1:0] bin_out,
  output logic [WIDTH-1:0] gray_out,
  output logic             wrap,
  output logic             at_limit
);

  localparam logic [WIDTH-1:0] C_MAX  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] C_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] C_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] r_gray;
  logic             r_wrap;

  logic [WIDTH-1:0] w_load_bin;
  logic [WIDTH-1:0] w_bin_next;
  logic [WIDTH-1:0] w_gray_next;
  logic             w_wrap_next;
  logic             w_at_max;
  logic             w_at_min;

  // Gray-to-binary conversion of the load value. Each binary bit is the XOR of
  // all Gray bits at or above it. The loop runs from the MSB down, so each
  // iteration reads the bit that the previous iteration wrote.
  always_comb begin
    w_load_bin            = C_ZERO;
    w_load_bin[WIDTH-1]   = load_gray[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      w_load_bin[i] = w_load_bin[i+1] ^ load_gray[i];
    end
  end

  assign w_at_max = (r_bin == C_MAX);
  assign w_at_min = (r_bin == C_ZERO);

  // Next-state selection. Priority is load, then en, then hold. At either end
  // of the range the count wraps only when WRAP_EN is set. Otherwise it holds,
  // and no wrap pulse is produced.
  always_comb begin
    w_bin_next  = r_bin;
    w_wrap_next = 1'b0;
    if (load) begin
      w_bin_next = w_load_bin;
    end else if (en) begin
      if (up_dn) begin
        if (!w_at_max) begin
          w_bin_next = r_bin + C_ONE;
        end else if (WRAP_EN) begin
          w_bin_next  = C_ZERO;
          w_wrap_next = 1'b1;
        end
      end else begin
        if (!w_at_min) begin
          w_bin_next = r_bin - C_ONE;
        end else if (WRAP_EN) begin
          w_bin_next  = C_MAX;
          w_wrap_next = 1'b1;
        end
      end
    end
  end

  // The Gray image is computed from the next binary value, not from the
  // current one. This keeps gray_out aligned with bin_out, with no one-cycle
  // lag. A load stores the supplied code directly, and that code is already
  // the Gray image of w_load_bin.
  assign w_gray_next = load ? load_gray : (w_bin_next ^ (w_bin_next >> 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bin  <= C_ZERO;
      r_gray <= C_ZERO;
      r_wrap <= 1'b0;
    end else begin
      r_bin  <= w_bin_next;
      r_gray <= w_gray_next;
      r_wrap <= w_wrap_next;
    end
  end

  assign bin_out  = r_bin;
  assign gray_out = r_gray;
  assign wrap     = r_wrap;

  // at_limit follows up_dn immediately, so a direction change updates it
  // without waiting for a clock edge.
  assign at_limit = up_dn ? w_at_max : w_at_min;

endmodule
`default_nettype wire

// File: tb/tb_gray_counter_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gray_counter_param
//  Description : Directed self-checking bench for gray_counter_param (WIDTH=4).
//                It runs a wrapping instance and a saturating instance side by
//                side, and both instances share the same input stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gray_counter_param;

  localparam int C_W = 4;

  logic           clk;
  logic           rst;
  logic           en;
  logic           up_dn;
  logic           load;
  logic [C_W-1:0] load_gray;

  logic [C_W-1:0] w_bin_w, w_gray_w;
  logic           w_wrap_w, w_lim_w;
  logic [C_W-1:0] w_bin_s, w_gray_s;
  logic           w_wrap_s, w_lim_s;

  int checks = 0;
  int errors = 0;

  gray_counter_param #(.WIDTH(C_W), .WRAP_EN(1'b1)) u_dut_wrap (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
    .load_gray(load_gray), .bin_out(w_bin_w), .gray_out(w_gray_w),
    .wrap(w_wrap_w), .at_limit(w_lim_w)
  );

  gray_counter_param #(.WIDTH(C_W), .WRAP_EN(1'b0)) u_dut_sat (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
    .load_gray(load_gray), .bin_out(w_bin_s), .gray_out(w_gray_s),
    .wrap(w_wrap_s), .at_limit(w_lim_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Gray codes of binary 0..15, worked out by hand.
  logic [3:0] c_gray_tbl [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                  4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

  initial begin
    logic [3:0] prev_gray;
    int         idx;

    rst = 1'b1; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_gray = '0;

    // T1: reset is held for two cycles.
    tick(); tick();
    check("t1_bin",   w_bin_w,  0);
    check("t1_gray",  w_gray_w, 0);
    check("t1_wrap",  w_wrap_w, 0);
    check("t1_limit", w_lim_w,  0);
    rst = 1'b0;

    // T2: a full up-count of 16 steps, ending with the wrap 15 -> 0.
    en = 1'b1; up_dn = 1'b1;
    prev_gray = 4'h0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      idx = k % 16;
      check("t2_bin",  w_bin_w,  idx);
      check("t2_gray", w_gray_w, c_gray_tbl[idx]);
      check("t2_wrap", w_wrap_w, (k == 16) ? 1 : 0);
      check("t2_onebit", $countones(w_gray_w ^ prev_gray), 1);
      check("t2_limit", w_lim_w, (idx == 15) ? 1 : 0);
      prev_gray = w_gray_w;
    end

    // T3: count down from 0, which wraps to max.
    up_dn = 1'b0;
    tick();
    check("t3_bin",  w_bin_w,  4'hF);
    check("t3_gray", w_gray_w, 4'h8);
    check("t3_wrap", w_wrap_w, 1);
    check("t3_limit", w_lim_w, 0);
    tick();
    check("t3_bin2",  w_bin_w,  4'hE);
    check("t3_gray2", w_gray_w, 4'h9);
    check("t3_wrap2", w_wrap_w, 0);

    // T4: load takes priority over en.
    load = 1'b1; load_gray = 4'b0110;
    tick();
    check("t4_bin",  w_bin_w,  4'b0100);
    check("t4_gray", w_gray_w, 4'b0110);
    check("t4_wrap", w_wrap_w, 0);

    // T5: the saturating instance holds at max. The wrapping instance is
    //     loaded with the same value and wraps instead.
    load_gray = 4'b1000;
    tick();
    check("t5_load_bin_s",  w_bin_s,  4'hF);
    check("t5_load_bin_w",  w_bin_w,  4'hF);
    load = 1'b0; up_dn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t5_bin_s",   w_bin_s,  4'hF);
      check("t5_gray_s",  w_gray_s, 4'h8);
      check("t5_wrap_s",  w_wrap_s, 0);
      check("t5_limit_s", w_lim_s,  1);
      check("t5_bin_w",   w_bin_w,  k);
      check("t5_wrap_w",  w_wrap_w, (k == 0) ? 1 : 0);
    end
    // The saturating instance must also hold at the bottom of the range.
    load = 1'b1; load_gray = 4'b0000;
    tick();
    load = 1'b0; up_dn = 1'b0;
    tick();
    check("t5_min_bin_s",   w_bin_s,  0);
    check("t5_min_wrap_s",  w_wrap_s, 0);
    check("t5_min_limit_s", w_lim_s,  1);

    // T6: hold at 0101, then an async reset mid-cycle, then resume counting.
    load = 1'b1; load_gray = 4'b0111; up_dn = 1'b1;
    tick();
    load = 1'b0; en = 1'b0;
    check("t6_bin_load", w_bin_w, 4'b0101);
    tick();
    check("t6_hold_bin",  w_bin_w,  4'b0101);
    check("t6_hold_gray", w_gray_w, 4'b0111);
    #2 rst = 1'b1;
    #1;
    check("t6_async_bin",  w_bin_w,  0);
    check("t6_async_gray", w_gray_w, 0);
    check("t6_async_wrap", w_wrap_w, 0);
    tick();
    rst = 1'b0; en = 1'b1; up_dn = 1'b1;
    tick();
    check("t6_resume_bin",  w_bin_w,  4'b0001);
    check("t6_resume_gray", w_gray_w, 4'b0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
